// File: rtl/burst_line_cache_pkg.sv
// Shared types and constants for the single-line burst cache.
package burst_line_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_BURST,
    S_WAIT_RAM,
    S_FILL_WAIT,
    S_RESPOND
  } state_e;

  localparam int BEAT_COUNT        = 4;
  localparam int BEAT_BITWIDTH     = 64;
  localparam int BEAT_IDX_BITWIDTH = $clog2(BEAT_COUNT);

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Pick the 32-bit half of a beat addressed by addr[2].
  function automatic logic [31:0] beat_word(input logic [BEAT_BITWIDTH-1:0] beat,
                                            input logic upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/burst_line_cache_if.sv
// CPU request port and burst-RAM port of the line cache, bundled together.
interface burst_line_cache_if
  import burst_line_cache_pkg::*;
#(
  parameter int ADDR_BITWIDTH      = 32,
  parameter int RAM_DEPTH_BITWIDTH = 4
);
  logic                          enable;
  logic [ADDR_BITWIDTH-1:0]      addr;
  logic [3:0]                    write_enable;
  logic [31:0]                   data_in;
  logic [31:0]                   data_out;
  logic                          data_out_ready;
  logic                          busy;

  logic                          br_cmd;
  logic                          br_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0] br_addr;
  logic [BEAT_BITWIDTH-1:0]      br_wr_data;
  logic [7:0]                    br_data_mask;
  logic [BEAT_BITWIDTH-1:0]      br_rd_data;
  logic                          br_rd_data_valid;
  logic                          br_busy;

  // The cache itself.
  modport slave (
    input  enable, addr, write_enable, data_in,
           br_rd_data, br_rd_data_valid, br_busy,
    output data_out, data_out_ready, busy,
           br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );

  // The CPU and burst RAM around it.
  modport master (
    output enable, addr, write_enable, data_in,
           br_rd_data, br_rd_data_valid, br_busy,
    input  data_out, data_out_ready, busy,
           br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_line_cache_merge.sv
// Byte-strobe merge of a 32-bit CPU write into one half of a 64-bit beat.
module burst_line_cache_merge
  import burst_line_cache_pkg::*;
(
  input  logic [BEAT_BITWIDTH-1:0] beat_i,
  input  logic                     word_sel_i,
  input  logic [3:0]               strobe_i,
  input  logic [31:0]              data_i,
  output logic [BEAT_BITWIDTH-1:0] beat_o
);
  logic [31:0] word_in;
  logic [31:0] word_out;

  // Replace only strobed bytes of the selected half, leave the other half alone.
  always_comb begin
    word_in  = beat_word(beat_i, word_sel_i);
    word_out = word_in;
    for (int b = 0; b < 4; b++) begin
      if (strobe_i[b]) word_out[8*b +: 8] = data_i[8*b +: 8];
    end
    beat_o = word_sel_i ? {word_out, beat_i[31:0]} : {beat_i[63:32], word_out};
  end
endmodule

// File: rtl/burst_line_cache.sv
// One-line (4 x 64-bit) write-back cache in front of a burst RAM.
// Writes are merged into the line while in S_RESPOND, so hits and fills
// share one merge path and data_out always shows the post-merge word.
module burst_line_cache
  import burst_line_cache_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH = 4,
  parameter int ADDR_BITWIDTH      = 32
)(
  input  logic               clk,
  input  logic               rst,
  burst_line_cache_if.slave  bus
);
  localparam int IDX_BITWIDTH = RAM_DEPTH_BITWIDTH - BEAT_IDX_BITWIDTH;

  state_e                       state_q, state_d;
  logic [BEAT_BITWIDTH-1:0]     line_q [BEAT_COUNT];
  logic [IDX_BITWIDTH-1:0]      line_idx_q, req_idx_q, idx_in;
  logic                         valid_q, dirty_q;
  logic [BEAT_IDX_BITWIDTH-1:0] beat_q, req_beat_q;
  logic                         req_word_q;
  logic [3:0]                   req_we_q;
  logic [31:0]                  req_data_q, data_out_q, resp_word;
  logic [BEAT_BITWIDTH-1:0]     merged_beat, wr_data;
  logic                         hit, accept, beat_adv, fill_store, fill_done, commit;
  logic                         cmd_en, cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] cmd_addr;
  logic                         unused_addr_bits;

  assign idx_in           = bus.addr[RAM_DEPTH_BITWIDTH+2:5];
  assign hit              = valid_q && (line_idx_q == idx_in);
  assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[ADDR_BITWIDTH-1:RAM_DEPTH_BITWIDTH+3]};

  burst_line_cache_merge u_merge (
    .beat_i     (line_q[req_beat_q]),
    .word_sel_i (req_word_q),
    .strobe_i   (req_we_q),
    .data_i     (req_data_q),
    .beat_o     (merged_beat)
  );
  assign resp_word = beat_word(merged_beat, req_word_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, RAM command outputs and datapath enables.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    beat_adv   = 1'b0;
    fill_store = 1'b0;
    fill_done  = 1'b0;
    commit     = 1'b0;
    cmd_en     = 1'b0;
    cmd        = CMD_READ;
    cmd_addr   = '0;
    wr_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          accept = 1'b1;
          if (hit)                    state_d = S_RESPOND;
          else if (valid_q && dirty_q) state_d = S_WB_BURST;
          else                        state_d = S_WAIT_RAM;
        end
      end
      S_WB_BURST: begin
        // Beat 0 carries the command and must wait for an idle RAM; beats 1-3 stream after it.
        if (beat_q != '0 || !bus.br_busy) begin
          beat_adv = 1'b1;
          wr_data  = line_q[beat_q];
          if (beat_q == '0) begin
            cmd_en   = 1'b1;
            cmd      = CMD_WRITE;
            cmd_addr = {line_idx_q, {BEAT_IDX_BITWIDTH{1'b0}}};
          end
          if (beat_q == BEAT_IDX_BITWIDTH'(BEAT_COUNT - 1)) state_d = S_WAIT_RAM;
        end
      end
      S_WAIT_RAM: begin
        if (!bus.br_busy) begin
          cmd_en   = 1'b1;
          cmd      = CMD_READ;
          cmd_addr = {req_idx_q, {BEAT_IDX_BITWIDTH{1'b0}}};
          state_d  = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (bus.br_rd_data_valid) begin
          fill_store = 1'b1;
          beat_adv   = 1'b1;
          if (beat_q == BEAT_IDX_BITWIDTH'(BEAT_COUNT - 1)) begin
            fill_done = 1'b1;
            state_d   = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line tag/flags, beat counter, captured request and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      dirty_q    <= 1'b0;
      line_idx_q <= '0;
      beat_q     <= '0;
      req_idx_q  <= '0;
      req_beat_q <= '0;
      req_word_q <= 1'b0;
      req_we_q   <= '0;
      req_data_q <= '0;
      data_out_q <= '0;
    end else begin
      if (beat_adv) beat_q <= beat_q + 1'b1;
      if (accept) begin
        req_idx_q  <= idx_in;
        req_beat_q <= bus.addr[4:3];
        req_word_q <= bus.addr[2];
        req_we_q   <= bus.write_enable;
        req_data_q <= bus.data_in;
      end
      if (fill_done) begin
        valid_q    <= 1'b1;
        dirty_q    <= 1'b0;
        line_idx_q <= req_idx_q;
      end
      if (commit) begin
        data_out_q <= resp_word;
        if (req_we_q != 4'b0000) dirty_q <= 1'b1;
      end
    end
  end

  // Line storage: filled beat by beat, then the pending write is merged in.
  always_ff @(posedge clk) begin
    if (fill_store)  line_q[beat_q]     <= bus.br_rd_data;
    else if (commit) line_q[req_beat_q] <= merged_beat;
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.data_out_ready = (state_q == S_RESPOND);
  assign bus.data_out       = (state_q == S_RESPOND) ? resp_word : data_out_q;
  assign bus.br_cmd_en      = cmd_en;
  assign bus.br_cmd         = cmd;
  assign bus.br_addr        = cmd_addr;
  assign bus.br_wr_data     = wr_data;
  assign bus.br_data_mask   = 8'h00;
endmodule

// File: doc/burst_line_cache.md
BURST_LINE_CACHE -- requirements
Module: burst_line_cache

Interface
REQ-001 Parameter RAM_DEPTH_BITWIDTH, 4, RAM address width in 8-byte words; must be a multiple-of-4 range, minimum 2.
REQ-002 Parameter ADDR_BITWIDTH, 32, CPU byte-address width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port enable  input  1  CPU request valid; sampled only when busy=0.
REQ-006 Port addr  input  ADDR_BITWIDTH  CPU byte address; bits [1:0] ignored.
REQ-007 Port write_enable  input  4  byte strobes; 0000 = read, else write of selected bytes.
REQ-008 Port data_in  input  32  CPU write data.
REQ-009 Port data_out  output  32  CPU read data.
REQ-010 Port data_out_ready  output  1  one-cycle pulse: request completed, data_out valid for reads.
REQ-011 Port busy  output  1  request in progress; enable ignored while high.
REQ-012 Ports br_cmd (1, 0 read / 1 write), br_cmd_en (1), br_addr (RAM_DEPTH_BITWIDTH), br_wr_data (64), br_data_mask (8, driven 0): outputs to the burst RAM.
REQ-013 Ports br_rd_data (64), br_rd_data_valid (1), br_busy (1): inputs from the burst RAM.

Function
REQ-014 Cache holds one 32-byte line (4 x 64-bit beats) plus line_index register, valid bit, dirty bit.
REQ-015 Address split: word-in-beat = addr[2], beat = addr[4:3], line_index = addr[RAM_DEPTH_BITWIDTH+2:5]; higher bits ignored (wrap-around).
REQ-016 Hit = valid AND stored line_index equals request line_index.
REQ-017 States: IDLE, WB_BURST, WAIT_RAM, FILL_WAIT, RESPOND.
REQ-018 IDLE, enable=1, hit: register the access; next cycle RESPOND drives data_out_ready=1 (read latency 1 cycle after enable), busy=1 during RESPOND only.
REQ-019 Write hit: merge data_in bytes per write_enable into selected 32-bit half of selected beat; set dirty.
REQ-020 Miss with valid AND dirty: wait for br_busy=0, then assert br_cmd_en=1, br_cmd=1, br_addr={stored line_index,2'b00} for exactly one cycle; br_wr_data presents beats 0,1,2,3 on that cycle and the 3 following cycles (WB_BURST).
REQ-021 After write-back or on clean miss: WAIT_RAM holds until br_busy=0, then pulses br_cmd_en=1, br_cmd=0, br_addr={request line_index,2'b00}; enter FILL_WAIT.
REQ-022 FILL_WAIT stores beats in order on each br_rd_data_valid=1 cycle; after 4th beat set valid=1, dirty=0, line_index=request; apply pending write merge (dirty=1 if write); go RESPOND.
REQ-023 RESPOND: data_out_ready=1 one cycle, data_out = selected 32-bit word (post-merge for writes), return to IDLE, busy=0 next cycle.
REQ-024 busy asserts the cycle after an accepted enable and deasserts the cycle after RESPOND; enable asserted during RESPOND is ignored.
REQ-025 br_cmd_en never asserted while br_busy=1; never asserted twice without an intervening burst.
REQ-026 Unexpected br_rd_data_valid outside FILL_WAIT ignored.
REQ-027 data_out holds last value between responses.

Reset
REQ-028 On rst: state IDLE, valid=0, dirty=0, busy=0, data_out_ready=0, data_out=0, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=0; line contents undefined.
REQ-029 Reset mid-burst abandons the burst; no completion pulse afterward; RAM shares rst and restarts clean.

Structure
REQ-030 Shared package holds state encodings, BEAT_COUNT=4, BEAT_BITWIDTH=64, RAM command constants (CMD_READ=0, CMD_WRITE=1).
REQ-031 One sub-module natural: burst_line_cache_merge (combinational 32-bit byte-strobe merge into a 64-bit beat).

Verification
REQ-032 Read 0x00000020 after reset, RAM line 1 = beats 0x1111..,0x2222..,0x3333..,0x4444.. -> one read burst at br_addr=4, data_out=0x11111111 lower half, no write burst.
REQ-033 Write 0xDEADBEEF strobe 1111 at 0x24, then read 0x24 -> hit, data_out_ready one cycle after enable, data_out=0xDEADBEEF, no RAM command.
REQ-034 Then read 0x40 -> write burst at br_addr=4 with beat 0 upper half 0xDEADBEEF, then read burst at br_addr=8, in that order.
REQ-035 Write strobe 0010 data 0x0000AB00 at 0x44 -> only byte 1 of that word changes, dirty set.
REQ-036 Enable pulsed while busy=1 -> ignored, exactly one data_out_ready per accepted request.
REQ-037 Assert rst during FILL_WAIT beat 2 -> busy=0, valid=0, no data_out_ready; next read of same line issues a fresh fill.
